wbm_pwm_fader: RTL and testbench



---
 rtl/wbm_pwm_fader.sv | 173 +++++++++++++++++
 tb/tb_wbm_pwm_fader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : wbm_pwm_fader
// Purpose  : Autonomous Wishbone master that ramps per-channel PWM duty values
//            one LSB per step tick toward software-loaded targets. It issues a
//            single write cycle to the PWM slave for every channel whose duty
//            changed. Channels are served in round-robin order.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            set_valid         - load set_target into tgt[set_channel]
//            set_channel       - channel index (out-of-range loads ignored)
//            set_target        - target duty, 0xFF = 100 %
//            busy              - any ramp, pending write or write in flight
//            wb_stb / wb_we    - bus strobe / write enable (identical)
//            wb_adr / wb_dat_c - channel index (zero-extended) / duty value
//            wb_ack            - slave acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module wbm_pwm_fader #(
    parameter int CHANNEL_NUM = 4,
    parameter int STEP_TICKS  = 1024,
    parameter int ADR_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_valid,
    input  logic [$clog2(CHANNEL_NUM)-1:0] set_channel,
    input  logic [7:0]                     set_target,
    output logic                           busy,
    output logic                           wb_stb,
    output logic                           wb_we,
    output logic [ADR_W-1:0]               wb_adr,
    output logic [7:0]                     wb_dat_c,
    input  logic                           wb_ack
);

    localparam int c_CH_W  = $clog2(CHANNEL_NUM);
    localparam int c_CNT_W = $clog2(STEP_TICKS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_CNT_W-1:0]       r_step_cnt;
    logic                     w_step;
    logic [7:0]               r_cur [CHANNEL_NUM];
    logic [7:0]               r_tgt [CHANNEL_NUM];
    logic [7:0]               w_cur_nxt [CHANNEL_NUM];
    logic [7:0]               w_tgt_nxt [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0]   r_dirty;
    logic [CHANNEL_NUM-1:0]   w_dirty_nxt;
    logic [CHANNEL_NUM-1:0]   w_moved;
    logic [c_CH_W-1:0]        r_rr;
    logic [c_CH_W-1:0]        w_rr_nxt;
    logic [c_CH_W-1:0]        w_sel;
    logic [c_CH_W:0]          w_cand;
    logic                     w_found;
    logic                     w_take;
    logic                     w_busy_nxt;

    assign w_step = (r_step_cnt == c_CNT_W'(STEP_TICKS - 1));
    assign wb_stb = (r_state == ST_SEND);
    assign wb_we  = wb_stb;

    // Ramp step and target load. The step compares against the target that
    // is registered now, so a load in the same cycle only affects later steps.
    always_comb begin
        for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
            w_cur_nxt[ch] = r_cur[ch];
            w_moved[ch]   = 1'b0;
            if (w_step && (r_cur[ch] < r_tgt[ch])) begin
                w_cur_nxt[ch] = r_cur[ch] + 8'd1;
                w_moved[ch]   = 1'b1;
            end else if (w_step && (r_cur[ch] > r_tgt[ch])) begin
                w_cur_nxt[ch] = r_cur[ch] - 8'd1;
                w_moved[ch]   = 1'b1;
            end
            w_tgt_nxt[ch] = r_tgt[ch];
            if (set_valid && (int'(set_channel) == ch)) begin
                w_tgt_nxt[ch] = set_target;
            end
        end
    end

    // Round-robin search starting at r_rr; candidate wraps modulo CHANNEL_NUM.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            w_cand = {1'b0, r_rr} + (c_CH_W+1)'(i);
            if (w_cand >= (c_CH_W+1)'(CHANNEL_NUM)) begin
                w_cand = w_cand - (c_CH_W+1)'(CHANNEL_NUM);
            end
            if (!w_found && r_dirty[w_cand[c_CH_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[c_CH_W-1:0];
            end
        end
    end

    // Next-state logic; w_take marks the cycle that latches a write.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (wb_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A step that moves the channel being taken keeps it dirty, so the newer
    // value is written later and the last write always matches cur.
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_SEND);
        for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
            w_dirty_nxt[ch] = (r_dirty[ch] && !(w_take && (w_sel == c_CH_W'(ch))))
                              || w_moved[ch];
            if (w_dirty_nxt[ch] || (w_cur_nxt[ch] != w_tgt_nxt[ch])) begin
                w_busy_nxt = 1'b1;
            end
        end
        w_rr_nxt = r_rr;
        if (w_take) begin
            w_rr_nxt = (w_sel == c_CH_W'(CHANNEL_NUM - 1)) ? '0 : w_sel + c_CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_rr       <= '0;
            // All channels start dirty so the PWM is resynchronised to zero.
            r_dirty    <= '1;
            busy       <= 1'b0;
            wb_adr     <= '0;
            wb_dat_c   <= '0;
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                r_cur[ch] <= '0;
                r_tgt[ch] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step ? '0 : r_step_cnt + c_CNT_W'(1);
            r_rr       <= w_rr_nxt;
            r_dirty    <= w_dirty_nxt;
            busy       <= w_busy_nxt;
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                r_cur[ch] <= w_cur_nxt[ch];
                r_tgt[ch] <= w_tgt_nxt[ch];
            end
            if (w_take) begin
                wb_adr   <= ADR_W'(w_sel);
                wb_dat_c <= r_cur[w_sel];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wbm_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbm_pwm_fader
// Purpose  : Self-checking bench for wbm_pwm_fader. Expected bus writes are
//            queued as stimulus is applied and compared as writes complete.
//            A second 3-channel instance covers out-of-range channel loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbm_pwm_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_valid;
    logic [1:0] set_channel;
    logic [7:0] set_target;
    logic       busy;
    logic       wb_stb;
    logic       wb_we;
    logic [3:0] wb_adr;
    logic [7:0] wb_dat_c;
    logic       wb_ack = 1'b0;

    logic       rst3;
    logic       set3_valid;
    logic [1:0] set3_channel;
    logic [7:0] set3_target;
    logic       busy3;
    logic       stb3;
    logic       we3;
    logic [3:0] adr3;
    logic [7:0] dat3;
    logic       ack3 = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          phase = 0;
    int          scnt = 0;
    int          ack_dly = 1;
    logic        ack_prev = 1'b0;
    logic        sb_mode = 1'b1;
    logic        chk_space = 1'b0;
    logic        have_prev = 1'b0;
    int          prev_cyc = 0;
    int          last_wr_cyc = 0;
    int          rr_n = 0;
    int          prev_adr = 0;
    logic [7:0]  last_dat [4];
    logic [15:0] sb_q [$];
    int          c3 = 0;
    int          n_wr3 = 0;
    logic [15:0] last3 = '0;

    always #5 clk = ~clk;

    wbm_pwm_fader #(.CHANNEL_NUM(4), .STEP_TICKS(4), .ADR_W(4)) u_dut (
        .clk(clk), .rst(rst), .set_valid(set_valid), .set_channel(set_channel),
        .set_target(set_target), .busy(busy), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_c(wb_dat_c), .wb_ack(wb_ack)
    );

    wbm_pwm_fader #(.CHANNEL_NUM(3), .STEP_TICKS(4), .ADR_W(4)) u_dut3 (
        .clk(clk), .rst(rst3), .set_valid(set3_valid), .set_channel(set3_channel),
        .set_target(set3_target), .busy(busy3), .wb_stb(stb3), .wb_we(we3),
        .wb_adr(adr3), .wb_dat_c(dat3), .wb_ack(ack3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter and step-phase reference (counter value during the cycle).
    always @(posedge clk) begin
        cyc++;
        if (rst) phase = 0;
        else     phase = (phase + 1) % 4;
    end

    // Slave with programmable ack delay plus write monitor / scoreboard.
    always @(negedge clk) begin
        logic        ok;
        logic [15:0] exp_w;
        logic [15:0] wr_w;
        if (ack_prev) check("stb_drop", wb_stb, 0);
        if (!wb_stb) begin
            wb_ack = 1'b0;
            scnt   = 0;
        end else begin
            wb_ack = (scnt == ack_dly);
            scnt++;
        end
        ack_prev = wb_stb && wb_ack;
        if (wb_stb && wb_ack) begin
            check("wr_we", wb_we, 1);
            wr_w        = {8'(wb_adr), wb_dat_c};
            last_wr_cyc = cyc;
            if (sb_mode) begin
                ok = (sb_q.size() != 0);
                check("wr_expected", ok, 1);
                if (ok) begin
                    exp_w = sb_q.pop_front();
                    check("wr_adr_dat", wr_w, exp_w);
                end
                if (chk_space) begin
                    if (have_prev) check("wr_spacing", cyc - prev_cyc, 4);
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
            end else begin
                rr_n++;
                if (rr_n > 8 && wb_dat_c < 8'hE0) check("rr_adr", wb_adr, (prev_adr + 1) % 4);
                prev_adr = int'(wb_adr);
                if (wb_adr < 4'd4) last_dat[wb_adr[1:0]] = wb_dat_c;
            end
        end
    end

    // Ack-next-cycle slave for the 3-channel instance.
    always @(negedge clk) begin
        if (!stb3) begin
            ack3 = 1'b0;
            c3   = 0;
        end else begin
            ack3 = (c3 == 1);
            c3++;
        end
        if (stb3 && we3 && ack3) begin
            n_wr3++;
            last3 = {8'(adr3), dat3};
        end
    end

    task automatic load(input int ch, input logic [7:0] v);
        @(negedge clk);
        set_valid   = 1'b1;
        set_channel = 2'(ch);
        set_target  = v;
        @(negedge clk);
        set_valid   = 1'b0;
    endtask

    task automatic push(input int ch, input logic [7:0] v);
        sb_q.push_back({8'(ch), v});
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb_q.size() != 0 || busy) && n < max);
        check("drain_busy", busy, 0);
        check("drain_sb", sb_q.size(), 0);
    endtask

    initial begin
        int n;
        int set_cyc;
        rst = 1'b1; set_valid = 1'b0; set_channel = '0; set_target = '0;
        rst3 = 1'b1; set3_valid = 1'b0; set3_channel = '0; set3_target = '0;
        for (int i = 0; i < 4; i++) last_dat[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_dat", wb_dat_c, 0);
        check("rst_busy", busy, 0);

        // Reset zeroing sequence.
        for (int i = 0; i < 4; i++) push(i, 8'h00);
        rst = 1'b0; rst3 = 1'b0;
        wait_idle(200);
        repeat (8) @(negedge clk);
        check("post_rst_stb", wb_stb, 0);
        check("post_rst_busy", busy, 0);
        check("dut3_zero_wr", n_wr3, 3);

        // Ramp up channel 1.
        have_prev = 1'b0; chk_space = 1'b1;
        push(1, 8'h01); push(1, 8'h02); push(1, 8'h03);
        load(1, 8'h03);
        wait_idle(200);
        chk_space = 1'b0;

        // Ramp down to zero, no wrap.
        push(0, 8'h01); push(0, 8'h02);
        load(0, 8'h02);
        wait_idle(200);
        push(0, 8'h01); push(0, 8'h00);
        load(0, 8'h00);
        wait_idle(200);
        repeat (12) @(negedge clk);
        check("floor_busy", busy, 0);

        // Load coincident with a step pulse: step uses the old target.
        for (int v = 1; v <= 5; v++) push(2, 8'(v));
        load(2, 8'h05);
        wait_idle(200);
        n = 0;
        while (phase != 3 && n < 8) begin @(negedge clk); n++; end
        push(2, 8'h06);
        set_valid = 1'b1; set_channel = 2'd2; set_target = 8'h06;
        set_cyc = cyc;
        @(negedge clk);
        set_valid = 1'b0;
        wait_idle(200);
        check("same_cycle_lat", last_wr_cyc - set_cyc, 7);

        // Contention: all channels ramp to 0xFF, slow slave.
        sb_mode = 1'b0; ack_dly = 3; rr_n = 0;
        for (int ch = 0; ch < 4; ch++) begin
            @(negedge clk);
            set_valid = 1'b1; set_channel = 2'(ch); set_target = 8'hFF;
        end
        @(negedge clk);
        set_valid = 1'b0;
        wait_idle(6000);
        for (int ch = 0; ch < 4; ch++) check("final_dat", last_dat[ch], 8'hFF);
        sb_mode = 1'b1; ack_dly = 1;
        repeat (4) @(negedge clk);

        // Reset while a write is in flight and ack is withheld.
        ack_dly = 255;
        load(3, 8'h20);
        n = 0;
        while (!wb_stb && n < 50) begin @(negedge clk); n++; end
        check("stb_seen", wb_stb, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_stb", wb_stb, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        ack_dly = 1;
        for (int i = 0; i < 4; i++) push(i, 8'h00);
        rst = 1'b0;
        wait_idle(200);

        // Out-of-range channel on the 3-channel instance, then an in-range one.
        @(negedge clk);
        set3_valid = 1'b1; set3_channel = 2'd3; set3_target = 8'h10;
        @(negedge clk);
        set3_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("oor_no_wr", n_wr3, 3);
        check("oor_busy", busy3, 0);
        @(negedge clk);
        set3_valid = 1'b1; set3_channel = 2'd2; set3_target = 8'h01;
        @(negedge clk);
        set3_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("inr_wr_cnt", n_wr3, 4);
        check("inr_wr", last3, 16'h0201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
